// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pac-Man game sequencer.
// Handshake: a move transfers on a clock edge where move_valid && move_ready are both high.
package pacman_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } move_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    PLAY  = 3'd2,
    DYING = 3'd3,
    CLEAR = 3'd4,
    OVER  = 3'd5
  } game_state_t;

  localparam int SCORE_PER_CANDY = 10;

  // Game step period shrinks by one cycle per level, never below 2.
  function automatic int unsigned step_period(input int unsigned tick_div, input logic [3:0] lvl);
    if (tick_div >= 32'(lvl) + 32'd2) begin
      return tick_div - 32'(lvl);
    end
    return 32'd2;
  endfunction

endpackage

// File: rtl/pacman_move_buf.sv
// One-entry move buffer. A drain empties it and, in the same cycle, a new
// move may be accepted; flush discards everything including that new move.
module pacman_move_buf
  import pacman_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  enable,
  input  logic  flush,
  input  logic  drain,
  input  logic  in_valid,
  input  move_t in_move,
  output logic  in_ready,
  output logic  full,
  output move_t out_move
);

  logic  full_q, full_d;
  move_t data_q, data_d;
  logic  fire;

  assign in_ready = enable && (!full_q || drain);
  assign fire     = in_valid && in_ready;
  assign full     = full_q;
  assign out_move = data_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (drain) begin
      full_d = 1'b0;
    end
    if (fire) begin
      full_d = 1'b1;
      data_d = in_move;
    end
    if (flush) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= RIGHT;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/pacman_game_ctrl.sv
// Round sequencer above the Pac-Man core: core reset/step generation,
// lives/score/level bookkeeping and the buffered player move path.
module pacman_game_ctrl
  import pacman_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int TICK_DIV     = 8,
  parameter int READY_CYCLES = 16,
  parameter int DYING_CYCLES = 16,
  parameter int CLEAR_CYCLES = 16,
  parameter int SCORE_W      = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               move_valid,
  input  logic [1:0]         move,
  output logic               move_ready,
  input  logic               core_catch,
  input  logic               core_candy_hit,
  input  logic               core_all_eaten,
  output logic               core_reset,
  output logic               core_step,
  output logic [1:0]         core_move,
  output game_state_t        state,
  output logic [1:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         level,
  output logic               game_over
);

  game_state_t        state_q, state_d;
  logic [15:0]        dwell_q, dwell_d;
  logic [15:0]        tick_q, tick_d;
  logic [1:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         level_q, level_d;
  logic               core_reset_q, core_reset_d;
  logic               core_step_q, core_step_d;
  logic               game_over_q, game_over_d;
  move_t              core_move_q, core_move_d;

  logic               dwell_done;
  logic               entering;
  logic               flush;
  logic               buf_full;
  move_t              buf_move;
  logic [SCORE_W:0]   score_sum;
  int unsigned        period;

  assign period    = step_period(TICK_DIV, level_q);
  assign score_sum = {1'b0, score_q} + (SCORE_W + 1)'(SCORE_PER_CANDY);

  pacman_move_buf u_move_buf (
    .clk      (clk),
    .rst_n    (reset_n),
    .enable   (state_q == READY || state_q == PLAY),
    .flush    (flush),
    .drain    (core_step_q),
    .in_valid (move_valid),
    .in_move  (move_t'(move)),
    .in_ready (move_ready),
    .full     (buf_full),
    .out_move (buf_move)
  );

  always_comb begin
    dwell_done = 1'b0;
    case (state_q)
      READY:   dwell_done = (dwell_q == 16'(READY_CYCLES - 1));
      DYING:   dwell_done = (dwell_q == 16'(DYING_CYCLES - 1));
      CLEAR:   dwell_done = (dwell_q == 16'(CLEAR_CYCLES - 1));
      default: dwell_done = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    score_d = score_q;
    level_d = level_q;
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d = READY;
          lives_d = 2'(LIVES);
          score_d = '0;
          level_d = '0;
        end
      end
      READY: begin
        if (dwell_done) state_d = PLAY;
      end
      PLAY: begin
        // Scoring uses the candy flag sampled on the step edge itself.
        if (core_step_q && core_candy_hit) begin
          score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        end
        if (core_catch) begin
          state_d = DYING;
        end else if (core_all_eaten) begin
          state_d = CLEAR;
        end
      end
      DYING: begin
        if (dwell_done) begin
          lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
          state_d = (lives_q <= 2'd1) ? OVER : READY;
        end
      end
      CLEAR: begin
        if (dwell_done) begin
          state_d = READY;
          level_d = (level_q == 4'd15) ? level_q : level_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    entering     = (state_d != state_q);
    flush        = entering && (state_d == DYING || state_d == CLEAR ||
                                state_d == OVER  || state_d == IDLE);
    dwell_d      = entering ? 16'd0 : dwell_q + 16'd1;
    if (!(state_d == READY || state_d == DYING || state_d == CLEAR)) begin
      dwell_d = 16'd0;
    end
    tick_d       = 16'd0;
    if (state_d == PLAY && !entering && tick_q != 16'(period - 32'd1)) begin
      tick_d = tick_q + 16'd1;
    end
    core_step_d  = (state_d == PLAY) && (tick_d == 16'(period - 32'd1));
    core_reset_d = (state_d == IDLE) || (state_d == OVER) ||
                   (state_d == READY && entering);
    game_over_d  = (state_d == OVER);
    core_move_d  = (core_step_q && buf_full) ? buf_move : core_move_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      dwell_q      <= 16'd0;
      tick_q       <= 16'd0;
      lives_q      <= 2'(LIVES);
      score_q      <= '0;
      level_q      <= 4'd0;
      core_reset_q <= 1'b1;
      core_step_q  <= 1'b0;
      core_move_q  <= RIGHT;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      dwell_q      <= dwell_d;
      tick_q       <= tick_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      level_q      <= level_d;
      core_reset_q <= core_reset_d;
      core_step_q  <= core_step_d;
      core_move_q  <= core_move_d;
      game_over_q  <= game_over_d;
    end
  end

  assign state      = state_q;
  assign lives      = lives_q;
  assign score      = score_q;
  assign level      = level_q;
  assign core_reset = core_reset_q;
  assign core_step  = core_step_q;
  assign core_move  = core_move_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_pacman_game_ctrl.sv
// Bench for pacman_game_ctrl: directed round scenarios plus random play,
// checked every cycle against a cycle-count based model of the game rules.
module tb_pacman_game_ctrl;
  import pacman_pkg::*;

  localparam int LIVES = 3;
  localparam int TICK_DIV = 8;
  localparam int NCYC = 16;
  localparam int SMAX16 = 65535;
  localparam int SMAX4 = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, start, move_valid, core_catch, core_candy_hit, core_all_eaten;
  logic [1:0] move;

  logic move_ready, core_reset, core_step, game_over;
  logic [1:0] core_move, lives;
  logic [15:0] score;
  logic [3:0] level;
  game_state_t state;

  logic move_ready4, core_reset4, core_step4, game_over4;
  logic [1:0] core_move4, lives4;
  logic [3:0] score4;
  logic [3:0] level4;
  game_state_t state4;

  pacman_game_ctrl #(.LIVES(LIVES), .TICK_DIV(TICK_DIV), .READY_CYCLES(NCYC),
    .DYING_CYCLES(NCYC), .CLEAR_CYCLES(NCYC), .SCORE_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .move_valid(move_valid), .move(move),
    .move_ready(move_ready), .core_catch(core_catch), .core_candy_hit(core_candy_hit),
    .core_all_eaten(core_all_eaten), .core_reset(core_reset), .core_step(core_step),
    .core_move(core_move), .state(state), .lives(lives), .score(score), .level(level),
    .game_over(game_over));

  pacman_game_ctrl #(.LIVES(LIVES), .TICK_DIV(TICK_DIV), .READY_CYCLES(NCYC),
    .DYING_CYCLES(NCYC), .CLEAR_CYCLES(NCYC), .SCORE_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .move_valid(move_valid), .move(move),
    .move_ready(move_ready4), .core_catch(core_catch), .core_candy_hit(core_candy_hit),
    .core_all_eaten(core_all_eaten), .core_reset(core_reset4), .core_step(core_step4),
    .core_move(core_move4), .state(state4), .lives(lives4), .score(score4), .level(level4),
    .game_over(game_over4));

  int total = 0;
  int bad = 0;

  // Model: state plus "cycles spent in this state, entry cycle = 1".
  game_state_t m_state;
  int m_dwell, m_lives, m_score, m_score4, m_level, m_buf, m_core_move;
  bit m_buf_full, m_step, m_core_reset;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return (m_state == READY || m_state == PLAY) && (!m_buf_full || m_step);
  endfunction

  task automatic model_reset();
    m_state = IDLE; m_dwell = 1; m_lives = LIVES; m_score = 0; m_score4 = 0;
    m_level = 0; m_buf_full = 0; m_buf = 3; m_core_move = 3; m_step = 0;
    m_core_reset = 1;
  endtask

  task automatic model_edge();
    game_state_t nxt;
    bit acc;
    int period;
    nxt = m_state;
    acc = m_ready() && move_valid;
    if (m_step && core_candy_hit) begin
      m_score  = (m_score + 10 > SMAX16) ? SMAX16 : m_score + 10;
      m_score4 = (m_score4 + 10 > SMAX4) ? SMAX4 : m_score4 + 10;
    end
    if (m_step && m_buf_full) begin
      m_core_move = m_buf;
      m_buf_full = 0;
    end
    if (acc) begin
      m_buf_full = 1;
      m_buf = int'(move);
    end
    case (m_state)
      IDLE, OVER: if (start) begin
        nxt = READY; m_lives = LIVES; m_score = 0; m_score4 = 0; m_level = 0;
      end
      READY: if (m_dwell == NCYC) nxt = PLAY;
      PLAY: begin
        if (core_catch) nxt = DYING;
        else if (core_all_eaten) nxt = CLEAR;
      end
      DYING: if (m_dwell == NCYC) begin
        m_lives = m_lives - 1;
        nxt = (m_lives == 0) ? OVER : READY;
      end
      CLEAR: if (m_dwell == NCYC) begin
        nxt = READY;
        if (m_level < 15) m_level = m_level + 1;
      end
      default: ;
    endcase
    if (nxt != m_state && nxt inside {DYING, CLEAR, OVER, IDLE}) m_buf_full = 0;
    m_dwell = (nxt != m_state) ? 1 : m_dwell + 1;
    m_state = nxt;
    period = (TICK_DIV - m_level > 2) ? TICK_DIV - m_level : 2;
    m_step = (m_state == PLAY) && (m_dwell % period == 0);
    m_core_reset = (m_state == IDLE || m_state == OVER) || (m_state == READY && m_dwell == 1);
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m_state));
    chk("lives", 32'(lives), 32'(m_lives));
    chk("score", 32'(score), 32'(m_score));
    chk("level", 32'(level), 32'(m_level));
    chk("core_reset", 32'(core_reset), 32'(m_core_reset));
    chk("core_step", 32'(core_step), 32'(m_step));
    chk("core_move", 32'(core_move), 32'(m_core_move));
    chk("game_over", 32'(game_over), 32'(m_state == OVER));
    chk("state4", 32'(state4), 32'(m_state));
    chk("score4", 32'(score4), 32'(m_score4));
    chk("lives4", 32'(lives4), 32'(m_lives));
    chk("level4", 32'(level4), 32'(m_level));
    chk("core_reset4", 32'(core_reset4), 32'(m_core_reset));
    chk("core_step4", 32'(core_step4), 32'(m_step));
    chk("core_move4", 32'(core_move4), 32'(m_core_move));
    chk("game_over4", 32'(game_over4), 32'(m_state == OVER));
  endtask

  task automatic check_reset_values();
    chk("rst_state", 32'(state), 32'(IDLE));
    chk("rst_lives", 32'(lives), 32'(LIVES));
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_core_step", 32'(core_step), 32'd0);
    chk("rst_core_move", 32'(core_move), 32'd3);
    chk("rst_move_ready", 32'(move_ready), 32'd0);
    chk("rst_game_over", 32'(game_over), 32'd0);
  endtask

  // One clock: combinational ready checked mid-cycle, registers after the edge.
  task automatic cycle();
    @(negedge clk);
    chk("move_ready", 32'(move_ready), 32'(m_ready()));
    chk("move_ready4", 32'(move_ready4), 32'(m_ready()));
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wait_state(input game_state_t tgt, input int budget);
    int n;
    n = 0;
    while (m_state != tgt && n < budget) begin
      cycle();
      n++;
    end
    if (m_state != tgt) begin
      total++;
      bad++;
      $error("FAIL wait_%s observed=%s expected=%s", tgt.name(), m_state.name(), tgt.name());
    end
  endtask

  task automatic wait_step(input int budget);
    int n;
    n = 0;
    while (!m_step && n < budget) begin
      cycle();
      n++;
    end
    if (!m_step) begin
      total++;
      bad++;
      $error("FAIL wait_step observed=0 expected=1");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_ready, n_rst, n_hits, guard;
    bit acc;

    reset_n = 1'b0; start = 1'b0; move_valid = 1'b0; move = 2'd0;
    core_catch = 1'b0; core_candy_hit = 1'b0; core_all_eaten = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    check_all();
    reset_n = 1'b1;
    cycle();

    // Start: READY for 16 cycles, core_reset only in the first.
    start = 1'b1;
    cycle();
    start = 1'b0;
    n_ready = (state == READY) ? 1 : 0;
    n_rst = (state == READY) ? int'(core_reset) : 0;
    guard = 0;
    while (m_state == READY && guard < 40) begin
      cycle();
      guard++;
      if (state == READY) begin
        n_ready++;
        n_rst += int'(core_reset);
      end
    end
    chk("ready_len", 32'(n_ready), 32'd16);
    chk("ready_core_reset_cycles", 32'(n_rst), 32'd1);
    chk("play_entered", 32'(state), 32'(PLAY));
    for (int k = 2; k <= 17; k++) begin
      cycle();
      chk("step_every_8", 32'(core_step), 32'(k % 8 == 0));
    end

    // Candy on three consecutive steps.
    core_candy_hit = 1'b1;
    n_hits = 0;
    guard = 0;
    while (n_hits < 3 && guard < 60) begin
      if (m_step) n_hits++;
      cycle();
      guard++;
    end
    core_candy_hit = 1'b0;
    chk("score_30", 32'(score), 32'd30);
    chk("score_sat_4bit", 32'(score4), 32'd15);

    // LEFT then UP back-to-back between steps.
    wait_step(20);
    cycle();
    move_valid = 1'b1;
    move = 2'(LEFT);
    cycle();
    move = 2'(UP);
    guard = 0;
    acc = 1'b0;
    while (!acc && guard < 20) begin
      acc = m_ready();
      cycle();
      guard++;
    end
    move_valid = 1'b0;
    chk("up_accepted_on_step", 32'(acc), 32'd1);
    chk("core_move_left", 32'(core_move), 32'(LEFT));
    wait_step(20);
    cycle();
    chk("core_move_up", 32'(core_move), 32'(UP));

    // Catch and all-eaten together: catch wins.
    core_catch = 1'b1;
    core_all_eaten = 1'b1;
    cycle();
    core_catch = 1'b0;
    core_all_eaten = 1'b0;
    chk("catch_wins_state", 32'(state), 32'(DYING));
    chk("catch_wins_level", 32'(level), 32'd0);
    wait_state(READY, 40);
    chk("lives_after_death", 32'(lives), 32'd2);

    // Clear six levels, then level 6 -> 7 with period 2.
    for (int i = 0; i < 7; i++) begin
      wait_state(PLAY, 40);
      core_all_eaten = 1'b1;
      cycle();
      core_all_eaten = 1'b0;
      wait_state(READY, 40);
      if (i == 5) chk("level_6", 32'(level), 32'd6);
    end
    chk("level_7", 32'(level), 32'd7);
    wait_state(PLAY, 40);
    cycle();
    chk("p2_step_a", 32'(core_step), 32'd1);
    cycle();
    chk("p2_step_b", 32'(core_step), 32'd0);
    cycle();
    chk("p2_step_c", 32'(core_step), 32'd1);

    // Lose the remaining two lives.
    core_catch = 1'b1;
    cycle();
    core_catch = 1'b0;
    wait_state(READY, 40);
    chk("lives_1", 32'(lives), 32'd1);
    wait_state(PLAY, 40);
    core_catch = 1'b1;
    cycle();
    core_catch = 1'b0;
    chk("dying_last", 32'(state), 32'(DYING));
    wait_state(OVER, 40);
    chk("over_game_over", 32'(game_over), 32'd1);
    chk("over_lives", 32'(lives), 32'd0);
    chk("over_core_reset", 32'(core_reset), 32'd1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("restart_state", 32'(state), 32'(READY));
    chk("restart_lives", 32'(lives), 32'd3);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_level", 32'(level), 32'd0);

    // Random play against the model.
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 19) == 0);
      move_valid = 1'($urandom_range(0, 1));
      move = 2'($urandom_range(0, 3));
      core_catch = ($urandom_range(0, 59) == 0);
      core_candy_hit = 1'($urandom_range(0, 1));
      core_all_eaten = ($urandom_range(0, 39) == 0);
      cycle();
    end
    move_valid = 1'b0; core_catch = 1'b0; core_candy_hit = 1'b0; core_all_eaten = 1'b0;

    // Asynchronous reset in the middle of PLAY.
    start = 1'b1;
    wait_state(PLAY, 120);
    start = 1'b0;
    core_candy_hit = 1'b1;
    repeat (3) cycle();
    core_candy_hit = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    chk("rst_hold_step", 32'(core_step), 32'd0);
    reset_n = 1'b1;
    cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (4) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pacman_game_ctrl.md
# pacman_game_ctrl

Game-level sequencer that sits above the Pac-Man core. It takes the core in and out of reset and strobes it one game step at a time. It buffers player move requests through a valid/ready handshake and keeps lives, score and level. It runs the round state machine: ready countdown, play, death, level clear and game over.

## Interface
- `LIVES`, 3: lives at game start, ≥1.
- `TICK_DIV`, 8: clock cycles per game step at level 0, ≥2.
- `READY_CYCLES`, 16: cycles spent in READY before play.
- `DYING_CYCLES`, 16: cycles spent in DYING.
- `CLEAR_CYCLES`, 16: cycles spent in CLEAR.
- `SCORE_W`, 16: score width.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: level-sensitive start request, honoured in IDLE and OVER.
- `move_valid` in 1: player move request valid.
- `move` in 2: requested direction, encoded 00 up, 01 down, 10 left, 11 right.
- `move_ready` out 1: buffer can accept a move.
- `core_catch` in 1: sticky catch flag from the core.
- `core_candy_hit` in 1: a candy is present under Pac-Man.
- `core_all_eaten` in 1: no candies remain.
- `core_reset` out 1: active-high reset to the core.
- `core_step` out 1: one-cycle clock-enable to the core.
- `core_move` out 2: direction presented to the core.
- `state` out 3: current FSM state (`game_state_t`).
- `lives` out 2: lives remaining.
- `score` out SCORE_W: current score.
- `level` out 4: current level.
- `game_over` out 1: high in OVER.

## Operation
- States and transitions:
  - IDLE to READY on `start`.
  - READY to PLAY after READY_CYCLES.
  - PLAY to DYING on `core_catch`.
  - PLAY to CLEAR on `core_all_eaten`.
  - DYING to READY, or to OVER when lives reach 0 after the decrement, after DYING_CYCLES.
  - CLEAR to READY after CLEAR_CYCLES; `level` increments, saturating at 15.
  - OVER to READY on `start`.
- On IDLE→READY and OVER→READY: `lives`=LIVES, `score`=0, `level`=0.
- DYING exit decrements `lives`.
- `core_reset` is high in IDLE and OVER. It is also high for exactly the first cycle of every READY entry, which restores core positions and candies. It is low otherwise.
- Step period P = max(TICK_DIV − level, 2). A cycle counter runs only in PLAY and clears on PLAY entry. `core_step` pulses when counter = P−1, then the counter wraps to 0. `core_step` is never high outside PLAY.
- Move buffer holds one entry.
  - `move_ready` = (state ∈ {READY, PLAY}) && (buffer empty || `core_step`).
  - On `core_step`, a buffered move becomes the new `core_move` and the buffer empties.
  - With the buffer empty, `core_move` holds its last value, so Pac-Man keeps going.
  - The buffer is flushed on entry to DYING, CLEAR, OVER and IDLE.
  - A handshake accepted in the same cycle as `core_step` fills the buffer after the drain.
- Score: on each `core_step` with `core_candy_hit`=1, add SCORE_PER_CANDY=10. Score saturates at 2^SCORE_W−1.
- Simultaneous `core_catch` and `core_all_eaten` in PLAY: catch wins, and the next state is DYING.
- `core_catch` and `core_all_eaten` are ignored outside PLAY.
- Reset asserted mid-game: everything returns asynchronously to reset values, with no pulse on `core_step`.
- Reset values:
  - `state`=IDLE, `lives`=LIVES, `score`=0, `level`=0.
  - `core_reset`=1, `core_step`=0, `core_move`=11.
  - `move_ready`=0, `game_over`=0, buffer empty.

## Timing
- All outputs are registered except `move_ready`, which is combinational from state, buffer and step.
- State changes one cycle after the triggering input is sampled high.
- First `core_step` after PLAY entry occurs P cycles later, counting the entry cycle as cycle 1.
- A move accepted in cycle t with the buffer empty appears on `core_move` in the cycle after the next `core_step`. The core samples it on that step's edge.
- Dwell counters: READY, DYING and CLEAR each last exactly N cycles including the entry cycle.

## Structure
- Package `pacman_pkg` holds:
  - `move_t` enum: UP, DOWN, LEFT, RIGHT.
  - `game_state_t` enum: IDLE, READY, PLAY, DYING, CLEAR, OVER.
  - `SCORE_PER_CANDY`.
- Sub-module `pacman_move_buf`: one-entry valid/ready buffer with flush and drain inputs.
- The FSM, step divider and counters live in the top module.

## Test plan
- Reset, then `start` pulse: READY for 16 cycles with `core_reset` high only in cycle 1. Then PLAY, and `core_step` every 8 cycles.
- PLAY, candy hit on 3 consecutive steps: `score`=30. Preload `score` near max (SCORE_W=4): saturates at 15.
- `core_catch` in PLAY with `lives`=1: DYING for 16 cycles, then OVER with `game_over`=1 and `lives`=0. `start` returns to READY with `lives`=3 and `score`=0.
- `core_catch` and `core_all_eaten` asserted in the same cycle: next state DYING, `level` unchanged.
- `core_all_eaten` at level 6, TICK_DIV=8: level becomes 7, step period is 2 on the next PLAY.
- Moves LEFT then UP offered back-to-back between steps: LEFT accepted, `move_ready` low until the step. LEFT drives the first step and UP the next. `reset_n` dropped mid-PLAY: all outputs return to reset values immediately.
